powerup_spawner: RTL
====================

Name: powerup_spawner

Overview:
- Consumes the pseudo-random powerup position, timer and type values from the random-number generator.
- Runs the full lifecycle of one powerup: random spawn delay, spawn at a random x, fall down the screen, then either a miss or a collection by the player.
- On collection, runs a timed effect window and reports the active effect type to the player/weapon logic.
- Advances once per frame, on frame_clk.

Parameters:
- X_MIN, 64, left offset added to the 9-bit random position (x = X_MIN + pos).
- SPAWN_MIN, 60, minimum spawn delay in frames, added to the 9-bit random timer.
- FALL_STEP, 2, pixels added to y per frame while falling.
- Y_LIMIT, 480, a next-y value >= Y_LIMIT is a miss.
- PU_SIZE, 16, powerup square size in pixels.
- PLAYER_W, 32, player hitbox width.
- PLAYER_H, 16, player hitbox height.
- EFFECT_FRAMES, 600, effect duration in frames.

Ports:
- frame_clk  in  1  frame clock
- Reset  in  1  asynchronous, active-high reset
- enable  in  1  game running; low freezes all state
- LFSR_powerup_pos  in  9  random x offset
- LFSR_powerup_timer  in  9  random extra spawn delay
- LFSR_powerup_type  in  2  random powerup type
- player_x  in  10  player hitbox left edge
- player_y  in  10  player hitbox top edge
- powerup_visible  out  1  powerup on screen
- powerup_x  out  10  powerup left edge
- powerup_y  out  10  powerup top edge
- powerup_type  out  2  type of the falling powerup
- effect_active  out  1  collected effect running
- effect_type  out  2  type of the active effect
- effect_remaining  out  10  frames left in the effect

Behaviour:
- Reset is asynchronous, active-high; the clock is frame_clk.
- While Reset is high: state=IDLE, cnt=0, and every output is 0.
- enable=0: all registers hold their values, including mid-fall and mid-effect.
- All updates happen on the rising edge of frame_clk with enable=1.
- The module samples the LFSR inputs only at the instants listed below; they are free-running otherwise.

State machine (IDLE, WAIT, FALL, EFFECT):
- IDLE: cnt <= SPAWN_MIN + LFSR_powerup_timer, as a 10-bit sum (max 571, no overflow); go to WAIT. IDLE lasts exactly one frame.
- WAIT, cnt>0: cnt <= cnt-1.
- WAIT, cnt==0: spawn and go to FALL.
  - powerup_x <= X_MIN + LFSR_powerup_pos (10-bit).
  - powerup_y <= 0.
  - powerup_type <= LFSR_powerup_type.
  - powerup_visible <= 1.
- FALL, collision check: uses the registered powerup_x/y against the current player_x/y. A hit requires both of:
  - powerup_x < player_x+PLAYER_W and powerup_x+PU_SIZE > player_x;
  - powerup_y < player_y+PLAYER_H and powerup_y+PU_SIZE > player_y.
  - All comparisons are 11-bit unsigned.
- FALL, hit: go to EFFECT.
  - effect_active <= 1.
  - effect_type <= powerup_type.
  - effect_remaining <= EFFECT_FRAMES.
  - powerup_visible <= 0.
- FALL, no hit and powerup_y+FALL_STEP >= Y_LIMIT: miss. powerup_visible <= 0; go to IDLE.
- FALL, otherwise: powerup_y <= powerup_y+FALL_STEP.
- If a hit and a miss occur on the same frame, the hit wins.
- EFFECT, effect_remaining > 1: decrement it.
- EFFECT, effect_remaining == 1: effect_remaining <= 0, effect_active <= 0, effect_type <= 0; go to IDLE.
- No new spawn occurs while an effect is running; only one powerup exists at a time.
- powerup_x, powerup_y and powerup_type hold their last values when not visible; consumers must gate on powerup_visible.
- Reset asserted mid-FALL or mid-EFFECT clears everything immediately (asynchronously). The first edge after release is the IDLE frame.

Test Plan:
- Reset, release, timer=0, enable=1 → first edge: WAIT with cnt=60. powerup_visible rises after the 62nd edge, with powerup_y=0.
- At spawn, pos=9'd100, type=2'b10 → powerup_x=164, powerup_type=2. Changing the LFSR inputs afterwards leaves x and type unchanged.
- Player at (0,400), spawn at x=164 (no overlap) → y steps 0,2,…,478. On the next edge powerup_visible=0 and state returns to IDLE (240 edges after spawn).
- Player at (160,100), spawn x=164 → hit detected when y=86 (86+16 > 100). Then effect_active=1, effect_type=spawn type, effect_remaining=600, decrementing to 0 after 600 edges; effect_active drops on that edge.
- enable=0 for 10 frames mid-fall and mid-effect → y and effect_remaining frozen; resume exactly where they stopped.
- Reset pulse mid-effect (remaining=300) → all outputs 0 at once; after release the delay restarts from IDLE with a fresh timer sample.

Source files
------------

// File: rtl/powerup_spawner.sv
// Single-powerup lifecycle: random spawn delay, fall, miss/collect, timed effect.
// Advances once per frame_clk edge while enable is high.
module powerup_spawner #(
  parameter int X_MIN         = 64,
  parameter int SPAWN_MIN     = 60,
  parameter int FALL_STEP     = 2,
  parameter int Y_LIMIT       = 480,
  parameter int PU_SIZE       = 16,
  parameter int PLAYER_W      = 32,
  parameter int PLAYER_H      = 16,
  parameter int EFFECT_FRAMES = 600
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic [8:0] LFSR_powerup_pos,
  input  logic [8:0] LFSR_powerup_timer,
  input  logic [1:0] LFSR_powerup_type,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic       powerup_visible,
  output logic [9:0] powerup_x,
  output logic [9:0] powerup_y,
  output logic [1:0] powerup_type,
  output logic       effect_active,
  output logic [1:0] effect_type,
  output logic [9:0] effect_remaining
);

  typedef enum logic [1:0] {IDLE, WAIT, FALL, EFFECT} state_t;

  state_t     state, state_nx;
  logic [9:0] cnt, cnt_nx;
  logic       vis_nx, eff_act_nx;
  logic [9:0] px_nx, py_nx, eff_rem_nx;
  logic [1:0] ptype_nx, eff_type_nx;

  // Collision and miss math is done 11 bits wide so player_x+PLAYER_W cannot wrap.
  logic [10:0] pu_x, pu_y, pl_x, pl_y, y_step;
  logic        hit_x, hit_y, hit, miss;

  assign pu_x   = {1'b0, powerup_x};
  assign pu_y   = {1'b0, powerup_y};
  assign pl_x   = {1'b0, player_x};
  assign pl_y   = {1'b0, player_y};
  assign y_step = pu_y + 11'(FALL_STEP);

  assign hit_x = (pu_x < pl_x + 11'(PLAYER_W)) && (pu_x + 11'(PU_SIZE) > pl_x);
  assign hit_y = (pu_y < pl_y + 11'(PLAYER_H)) && (pu_y + 11'(PU_SIZE) > pl_y);
  assign hit   = hit_x && hit_y;
  assign miss  = y_step >= 11'(Y_LIMIT);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    vis_nx      = powerup_visible;
    px_nx       = powerup_x;
    py_nx       = powerup_y;
    ptype_nx    = powerup_type;
    eff_act_nx  = effect_active;
    eff_type_nx = effect_type;
    eff_rem_nx  = effect_remaining;
    case (state)
      IDLE: begin
        cnt_nx   = 10'(SPAWN_MIN) + {1'b0, LFSR_powerup_timer};
        state_nx = WAIT;
      end
      WAIT: begin
        if (cnt != 10'd0) begin
          cnt_nx = cnt - 10'd1;
        end else begin
          px_nx    = 10'(X_MIN) + {1'b0, LFSR_powerup_pos};
          py_nx    = 10'd0;
          ptype_nx = LFSR_powerup_type;
          vis_nx   = 1'b1;
          state_nx = FALL;
        end
      end
      FALL: begin
        // A hit on the bottom frame still counts as a collection.
        if (hit) begin
          vis_nx      = 1'b0;
          eff_act_nx  = 1'b1;
          eff_type_nx = powerup_type;
          eff_rem_nx  = 10'(EFFECT_FRAMES);
          state_nx    = EFFECT;
        end else if (miss) begin
          vis_nx   = 1'b0;
          state_nx = IDLE;
        end else begin
          py_nx = y_step[9:0];
        end
      end
      EFFECT: begin
        if (effect_remaining > 10'd1) begin
          eff_rem_nx = effect_remaining - 10'd1;
        end else begin
          eff_rem_nx  = 10'd0;
          eff_act_nx  = 1'b0;
          eff_type_nx = 2'd0;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state            <= IDLE;
      cnt              <= 10'd0;
      powerup_visible  <= 1'b0;
      powerup_x        <= 10'd0;
      powerup_y        <= 10'd0;
      powerup_type     <= 2'd0;
      effect_active    <= 1'b0;
      effect_type      <= 2'd0;
      effect_remaining <= 10'd0;
    end else if (enable) begin
      state            <= state_nx;
      cnt              <= cnt_nx;
      powerup_visible  <= vis_nx;
      powerup_x        <= px_nx;
      powerup_y        <= py_nx;
      powerup_type     <= ptype_nx;
      effect_active    <= eff_act_nx;
      effect_type      <= eff_type_nx;
      effect_remaining <= eff_rem_nx;
    end
  end

endmodule
